// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for multicycle_alu and its testbench.
//
// Contents:
//   OP_*    : 4-bit opcode constants carried on SELECT.
//   state_e : FSM state encoding of the ALU controller.
//
// Configuration macro: ALU_MULT_EN. When undefined the MUL state is not part
// of the encoding.
package alu_pkg;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_SRL = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;

`ifdef ALU_MULT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIN  = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier -- iterative unsigned shift-add multiplier.
//
// One partial product is accumulated per clock, so a multiply takes WIDTH
// cycles after the start edge. Only the low WIDTH bits of the product are
// kept; bits shifted out of the multiplicand can never reach them.
//
// Ports:
//   CLK     : clock, rising edge.
//   RESET   : synchronous active-high reset; aborts a multiply in progress.
//   start   : load a/b and begin a multiply (ignored-safe restart).
//   a, b    : operands, sampled on the start edge.
//   product : low WIDTH bits of a*b, valid from the done pulse onward.
//   done    : one-cycle pulse after the last partial product is added.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      // Multiplier bit i is examined while the multiplicand holds a << i.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign product = acc_q;
  assign done    = done_q;

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu -- small multi-cycle ALU with a start/busy/done handshake.
//
// A request is accepted when START=1 while BUSY=0; opcode and operands are
// latched on that edge. Single-step ops pass IDLE->EXEC->FIN->IDLE and pulse
// DONE two cycles after accept; MUL waits in the MUL state for the iterative
// multiplier and pulses DONE WIDTH+2 cycles after accept. RESULT and ZERO are
// loaded only on the FIN->IDLE edge, so they hold between completions.
//
// Ports:
//   CLK    : clock, rising edge.
//   RESET  : synchronous active-high reset; aborts any operation.
//   START  : request, sampled only while BUSY=0.
//   SELECT : opcode (see alu_pkg OP_*).
//   DATA1  : operand A.
//   DATA2  : operand B, or shift/rotate amount.
//   RESULT : registered result.
//   ZERO   : registered, 1 when RESULT is 0.
//   BUSY   : 1 while an operation is in flight.
//   DONE   : one-cycle pulse in the cycle RESULT/ZERO update.
//
// Configuration macro: ALU_MULT_EN -- when defined the MUL opcode uses the
// seq_multiplier sub-module; when undefined opcode 1000 is undefined (RESULT 0).
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int               SH_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic [SH_W-1:0]  rot_amt;
  logic [2*WIDTH-1:0] rot_wide;

  assign accept   = START && (state_q == ST_IDLE);
  assign rot_amt  = b_q[SH_W-1:0];
  // Rotating a doubled copy right leaves the rotated word in the low half.
  assign rot_wide = {a_q, a_q} >> rot_amt;

`ifdef ALU_MULT_EN
  logic [WIDTH-1:0] mul_product;
  logic             mul_done;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (accept && (SELECT == OP_MUL)),
    .a       (DATA1),
    .b       (DATA2),
    .product (mul_product),
    .done    (mul_done)
  );
`endif

  // Result selection from the latched operands; read only in FIN.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_MOV: alu_res = b_q;
      OP_ADD: alu_res = a_q + b_q;
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_SRL: alu_res = (b_q >= WIDTH_V) ? '0 : (a_q >> b_q);
      OP_SLL: alu_res = (b_q >= WIDTH_V) ? '0 : (a_q << b_q);
      // An arithmetic shift by WIDTH or more saturates to all sign bits.
      OP_SRA: alu_res = (b_q >= WIDTH_V) ? {WIDTH{a_q[WIDTH-1]}}
                                          : WIDTH'($signed(a_q) >>> b_q);
      OP_ROR: alu_res = rot_wide[WIDTH-1:0];
`ifdef ALU_MULT_EN
      OP_MUL: alu_res = mul_product;
`endif
      default: alu_res = '0;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = SELECT;
          a_d  = DATA1;
          b_d  = DATA2;
`ifdef ALU_MULT_EN
          state_d = (SELECT == OP_MUL) ? ST_MUL : ST_EXEC;
`else
          state_d = ST_EXEC;
`endif
        end
      end
      ST_EXEC: state_d = ST_FIN;
`ifdef ALU_MULT_EN
      ST_MUL: begin
        if (mul_done) state_d = ST_FIN;
      end
`endif
      ST_FIN: begin
        state_d  = ST_IDLE;
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        done_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MOV;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign RESULT = result_q;
  assign ZERO   = zero_q;
  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = done_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu -- self-checking bench for multicycle_alu (WIDTH=8).
//
// Directed table of vectors, hand-written multi-cycle sequences (MUL timing,
// ignored START, reset abort, reset priority) and randomized operations
// checked against a behavioural reference model. Honors ALU_MULT_EN.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   select = 4'h0;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] data2 = '0;
  logic [W-1:0] result;
  logic         zero, busy, done;

  int n_vec  = 0;
  int n_fail = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .CLK    (clk),
    .RESET  (reset),
    .START  (start),
    .SELECT (select),
    .DATA1  (data1),
    .DATA2  (data2),
    .RESULT (result),
    .ZERO   (zero),
    .BUSY   (busy),
    .DONE   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the opcode definitions, integer arithmetic.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int ia = a;
    int ib = b;
    int m  = 1 << W;
    int r  = 0;
    int n;
    int sa;
    case (op)
      OP_MOV: r = ib;
      OP_ADD: r = (ia + ib) % m;
      OP_AND: r = ia & ib;
      OP_OR:  r = ia | ib;
      OP_SRL: r = (ib >= W) ? 0 : ia / (1 << ib);
      OP_SLL: r = (ib >= W) ? 0 : (ia * (1 << ib)) % m;
      OP_ROR: begin
        n = ib % W;
        r = ia / (1 << n) + (ia * (1 << (W - n))) % m;
      end
      OP_SRA: begin
        sa = (ia >= m / 2) ? ia - m : ia;
        n  = (ib >= W) ? W - 1 : ib;
        r  = sa >>> n;
        if (r < 0) r = r + m;
      end
      OP_MUL: begin
`ifdef ALU_MULT_EN
        r = (ia * ib) % m;
`else
        r = 0;
`endif
      end
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  function automatic int ref_latency(input logic [3:0] op);
`ifdef ALU_MULT_EN
    if (op == OP_MUL) return W + 2;
`endif
    return 2;
  endfunction

  // Issue one operation from idle and wait (bounded) for DONE. Optionally
  // toggles random requests while busy; they must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input logic exp_zero, input bit noise);
    logic [W-1:0] prev;
    int           lat;
    bit           got;
    bit           held;
    prev   = result;
    start  = 1'b1;
    select = op;
    data1  = a;
    data2  = b;
    tick();
    start = 1'b0;
    got   = 1'b0;
    held  = 1'b1;
    lat   = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        select = 4'($urandom);
        data1  = W'($urandom);
        data2  = W'($urandom);
      end
      tick();
      lat = k;
      if (done) got = 1'b1;
      else if (result !== prev || busy !== 1'b1) held = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, ref_latency(op));
    check({tag, "_hold"}, held, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, zero, exp_zero);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b, er;
    bit           saw;
    bit           bad;

    vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2]  = '{OP_SRL, 8'h90, 8'h09, 8'h00, 1'b1};
    vecs[3]  = '{OP_SRA, 8'h90, 8'h09, 8'hFF, 1'b0};
    vecs[4]  = '{OP_SLL, 8'h90, 8'h03, 8'h80, 1'b0};
    vecs[5]  = '{OP_ROR, 8'h81, 8'h09, 8'hC0, 1'b0};
    vecs[6]  = '{OP_ROR, 8'h81, 8'h00, 8'h81, 1'b0};
    vecs[7]  = '{OP_MOV, 8'h12, 8'h34, 8'h34, 1'b0};
    vecs[8]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[9]  = '{OP_OR,  8'hF0, 8'h0C, 8'hFC, 1'b0};
    vecs[10] = '{OP_SRA, 8'h70, 8'h02, 8'h1C, 1'b0};
    vecs[11] = '{OP_SRL, 8'h90, 8'h04, 8'h09, 1'b0};
    vecs[12] = '{OP_SLL, 8'h90, 8'h08, 8'h00, 1'b1};
    vecs[13] = '{4'hF,   8'h55, 8'hAA, 8'h00, 1'b1};

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_result", result, 0);
    check("reset_zero", zero, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Directed table.
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_zero, 1'b0);

`ifdef ALU_MULT_EN
    // MUL 13*21 with an ADD request at n+4 that must be ignored.
    start  = 1'b1;
    select = OP_MUL;
    data1  = 8'd13;
    data2  = 8'd21;
    tick();                         // accept edge n
    start = 1'b0;
    bad   = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) begin
        start  = 1'b1;
        select = OP_ADD;
        data1  = 8'h01;
        data2  = 8'h01;
      end
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      tick();                       // edge n+k
      if (k == 4) start = 1'b0;
    end
    check("mul_busy_window", bad, 0);
    check("mul_busy_n9", busy, 1);
    tick();                         // edge n+10
    check("mul_done_n10", done, 1);
    check("mul_result", result, 8'h11);
    check("mul_zero", zero, 0);
    check("mul_idle_n10", busy, 0);
    saw = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) saw = 1'b1;
      if (busy !== 1'b0 || result !== 8'h11) bad = 1'b1;
    end
    check("mul_ignored_start_done", saw, 0);
    check("mul_ignored_start_state", bad, 0);

    // Reset abort of a MUL at edge n+3.
    start  = 1'b1;
    select = OP_MUL;
    data1  = 8'd7;
    data2  = 8'd9;
    tick();                         // n
    start = 1'b0;
    tick();                         // n+1
    tick();                         // n+2
    reset = 1'b1;
    tick();                         // n+3
    reset = 1'b0;
`else
    // MUL without the multiplier: undefined opcode, two-cycle completion.
    run_op("mul_disabled", OP_MUL, 8'd3, 8'd3, 8'h00, 1'b1, 1'b0);
    run_op("pre_abort", OP_ADD, 8'h10, 8'h01, 8'h11, 1'b0, 1'b0);
    start  = 1'b1;
    select = OP_ADD;
    data1  = 8'h22;
    data2  = 8'h01;
    tick();                         // n
    start = 1'b0;
    reset = 1'b1;
    tick();                         // n+1
    reset = 1'b0;
`endif
    check("abort_result", result, 0);
    check("abort_zero", zero, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    saw = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (done) saw = 1'b1;
      if (busy !== 1'b0 || result !== 8'h00) bad = 1'b1;
    end
    check("abort_no_done", saw, 0);
    check("abort_stays_idle", bad, 0);

    // Reset wins over a simultaneous START.
    run_op("pre_prio", OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    reset  = 1'b1;
    start  = 1'b1;
    select = OP_ADD;
    data1  = 8'h05;
    data2  = 8'h05;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("prio_busy", busy, 0);
    check("prio_result", result, 0);
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) saw = 1'b1;
    end
    check("prio_no_done", saw, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(9, 15));
      else op = 4'($urandom_range(0, 8));
      a = W'($urandom);
      b = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 12)) : W'($urandom);
      er = ref_alu(op, a, b);
      run_op($sformatf("rnd%0d_op%0h", i, op), op, a, b, er, (er == '0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
